// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interruptor.
package clint_pkg;

  localparam int unsigned MSIP_BASE     = 32'h0000;
  localparam int unsigned MTIMECMP_BASE = 32'h4000;
  localparam int unsigned CTRL_OFS      = 32'hBFF0;
  localparam int unsigned MTIME_LO_OFS  = 32'hBFF8;
  localparam int unsigned MTIME_HI_OFS  = 32'hBFFC;

  localparam int CTRL_EN_BIT    = 31;
  localparam int CTRL_PRESC_LSB = 0;

  // Laid out exactly as the CTRL word: en at bit 31, presc from bit 0 upward.
  typedef struct packed {
    logic        en;
    logic [30:0] presc;
  } clint_ctrl_t;

endpackage

// File: rtl/clint_hart.sv
// Per-hart state: mtimecmp, MSIP and the registered timer/software interrupts.
module clint_hart #(
  parameter int RSZ = 32
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             msip_we,
  input  logic             cmp_lo_we,
  input  logic             cmp_hi_we,
  input  logic             msip_sel,
  input  logic             cmp_lo_sel,
  input  logic             cmp_hi_sel,
  input  logic [RSZ-1:0]   wr_data,
  input  logic [2*RSZ-1:0] mtime,
  output logic [RSZ-1:0]   rd_data,
  output logic             timer_irq,
  output logic             sw_irq
);

  logic [2*RSZ-1:0] cmp;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cmp       <= '1;
      sw_irq    <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      if (cmp_lo_we) cmp[RSZ-1:0]     <= wr_data;
      if (cmp_hi_we) cmp[2*RSZ-1:RSZ] <= wr_data;
      if (msip_we)   sw_irq           <= wr_data[0];
      // Compare uses pre-edge register values, so irq lags any change by one cycle.
      timer_irq <= (mtime >= cmp);
    end
  end

  always_comb begin
    rd_data = '0;
    if (msip_sel)        rd_data = RSZ'(sw_irq);
    else if (cmp_lo_sel) rd_data = cmp[RSZ-1:0];
    else if (cmp_hi_sel) rd_data = cmp[2*RSZ-1:RSZ];
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor top: prescaler, shared mtime, CTRL, address decode and read return.
module clint_timer
  import clint_pkg::*;
#(
  parameter int NUM_HARTS = 1,
  parameter int RSZ       = 32,
  parameter int ADDR_W    = 16,
  parameter int PRESC_W   = 8
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [ADDR_W-1:0]    mmr_addr,
  input  logic                 mmr_wr,
  input  logic                 mmr_rd,
  input  logic [RSZ-1:0]       mmr_wr_data,
  output logic [RSZ-1:0]       mmr_rd_data,
  output logic                 mmr_rd_valid,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] sw_irq,
  output logic [2*RSZ-1:0]     mtime
);

  localparam int WW = ADDR_W - 2;
  localparam logic [WW-1:0] W_MSIP_BASE = WW'(MSIP_BASE >> 2);
  localparam logic [WW-1:0] W_CMP_BASE  = WW'(MTIMECMP_BASE >> 2);
  localparam logic [WW-1:0] W_CTRL      = WW'(CTRL_OFS >> 2);
  localparam logic [WW-1:0] W_MLO       = WW'(MTIME_LO_OFS >> 2);
  localparam logic [WW-1:0] W_MHI       = WW'(MTIME_HI_OFS >> 2);
  localparam logic [WW-1:0] W_NH        = WW'(NUM_HARTS);
  localparam logic [WW-1:0] W_NH2       = WW'(2 * NUM_HARTS);

  logic [WW-1:0] word, msip_ofs, cmp_ofs;
  logic          msip_hit, cmp_hit;
  logic          unused_addr;

  assign word        = mmr_addr[ADDR_W-1:2];
  assign unused_addr = ^mmr_addr[1:0];
  // Offsets wrap below the base, so a single unsigned upper bound covers both ends.
  assign msip_ofs    = word - W_MSIP_BASE;
  assign cmp_ofs     = word - W_CMP_BASE;
  assign msip_hit    = msip_ofs < W_NH;
  assign cmp_hit     = cmp_ofs < W_NH2;

  clint_ctrl_t        ctrl_q;
  logic [PRESC_W-1:0] cnt;
  logic [2*RSZ-1:0]   mtime_q;
  logic               tick, ctrl_we, mlo_we, mhi_we;

  assign ctrl_we = mmr_wr && (word == W_CTRL);
  assign mlo_we  = mmr_wr && (word == W_MLO);
  assign mhi_we  = mmr_wr && (word == W_MHI);
  assign tick    = ctrl_q.en && (cnt == ctrl_q.presc[PRESC_W-1:0]);
  assign mtime   = mtime_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ctrl_q <= '{en: 1'b1, presc: '0};
      cnt    <= '0;
    end else begin
      if (ctrl_we) begin
        ctrl_q <= '{en: mmr_wr_data[CTRL_EN_BIT],
                    presc: 31'(mmr_wr_data[CTRL_PRESC_LSB +: PRESC_W])};
        cnt    <= '0;
      end else if (ctrl_q.en) begin
        cnt <= tick ? '0 : cnt + PRESC_W'(1);
      end
    end
  end

  // A software write to either half takes priority over the tick; no carry across halves.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      mtime_q <= '0;
    end else if (mlo_we || mhi_we) begin
      if (mlo_we) mtime_q[RSZ-1:0]     <= mmr_wr_data;
      if (mhi_we) mtime_q[2*RSZ-1:RSZ] <= mmr_wr_data;
    end else if (tick) begin
      mtime_q <= mtime_q + (2*RSZ)'(1);
    end
  end

  logic [NUM_HARTS-1:0]          sel_msip, sel_lo, sel_hi;
  logic [NUM_HARTS-1:0][RSZ-1:0] hart_rd;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    localparam logic [WW-1:0] HM  = WW'(h);
    localparam logic [WW-1:0] HLO = WW'(2 * h);
    localparam logic [WW-1:0] HHI = WW'(2 * h + 1);

    assign sel_msip[h] = msip_hit && (msip_ofs == HM);
    assign sel_lo[h]   = cmp_hit && (cmp_ofs == HLO);
    assign sel_hi[h]   = cmp_hit && (cmp_ofs == HHI);

    clint_hart #(.RSZ(RSZ)) u_hart (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .msip_we   (mmr_wr && sel_msip[h]),
      .cmp_lo_we (mmr_wr && sel_lo[h]),
      .cmp_hi_we (mmr_wr && sel_hi[h]),
      .msip_sel  (sel_msip[h]),
      .cmp_lo_sel(sel_lo[h]),
      .cmp_hi_sel(sel_hi[h]),
      .wr_data   (mmr_wr_data),
      .mtime     (mtime_q),
      .rd_data   (hart_rd[h]),
      .timer_irq (timer_irq[h]),
      .sw_irq    (sw_irq[h])
    );
  end

  logic [RSZ-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (word == W_CTRL)     rd_mux = RSZ'(ctrl_q);
    else if (word == W_MLO) rd_mux = mtime_q[RSZ-1:0];
    else if (word == W_MHI) rd_mux = mtime_q[2*RSZ-1:RSZ];
    for (int h = 0; h < NUM_HARTS; h++) rd_mux = rd_mux | hart_rd[h];
  end

  // Sampled from pre-edge state, so a read colliding with a write returns the old value.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      mmr_rd_data  <= '0;
      mmr_rd_valid <= 1'b0;
    end else begin
      mmr_rd_valid <= mmr_rd;
      if (mmr_rd) mmr_rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer (2 harts): reads go through a scoreboard queue, state is checked directly.
module tb_clint_timer;

  localparam logic [15:0] A_CTRL = 16'hBFF0;
  localparam logic [15:0] A_MLO  = 16'hBFF8;
  localparam logic [15:0] A_MHI  = 16'hBFFC;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [15:0] mmr_addr = '0;
  logic        mmr_wr = 1'b0;
  logic        mmr_rd = 1'b0;
  logic [31:0] mmr_wr_data = '0;
  logic [31:0] mmr_rd_data;
  logic        mmr_rd_valid;
  logic [1:0]  timer_irq;
  logic [1:0]  sw_irq;
  logic [63:0] mtime;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  clint_timer #(.NUM_HARTS(2), .RSZ(32), .ADDR_W(16), .PRESC_W(8)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .mmr_addr    (mmr_addr),
    .mmr_wr      (mmr_wr),
    .mmr_rd      (mmr_rd),
    .mmr_wr_data (mmr_wr_data),
    .mmr_rd_data (mmr_rd_data),
    .mmr_rd_valid(mmr_rd_valid),
    .timer_irq   (timer_irq),
    .sw_irq      (sw_irq),
    .mtime       (mtime)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every returned read is matched against the oldest expectation.
  always @(negedge clk_in) begin
    if (!reset_in && mmr_rd_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rd_valid: got data %h expected no read", mmr_rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (mmr_rd_data !== e) begin
          fails++;
          $display("FAIL rd_data: got %h expected %h", mmr_rd_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    mmr_addr = a; mmr_wr_data = d; mmr_wr = 1'b1;
    cyc();
    mmr_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e);
    mmr_addr = a; mmr_rd = 1'b1;
    exp_q.push_back(e);
    cyc();
    mmr_rd = 1'b0;
  endtask

  task automatic rdwr(input logic [15:0] a, input logic [31:0] d, input logic [31:0] e);
    mmr_addr = a; mmr_wr_data = d; mmr_wr = 1'b1; mmr_rd = 1'b1;
    exp_q.push_back(e);
    cyc();
    mmr_wr = 1'b0; mmr_rd = 1'b0;
  endtask

  initial begin
    #1 reset_in = 1'b1;
    repeat (3) cyc();
    chk("reset_mtime", mtime, 64'd0);
    chk("reset_timer_irq", 64'(timer_irq), 64'd0);
    chk("reset_sw_irq", 64'(sw_irq), 64'd0);
    chk("reset_rd_valid", 64'(mmr_rd_valid), 64'd0);
    chk("reset_rd_data", 64'(mmr_rd_data), 64'd0);
    reset_in = 1'b0;

    // Free-running mtime, PRESC=0, and mtimecmp reset value.
    cyc();
    rd(A_MLO, 32'd1);
    rd(A_MLO, 32'd2);
    rd(A_MLO, 32'd3);
    rd(16'h4000, 32'hFFFF_FFFF);
    rd(16'h4004, 32'hFFFF_FFFF);
    chk("irq_idle", 64'(timer_irq), 64'd0);

    // mtimecmp[1] = 20: irq[1] rises one cycle after mtime reaches 20.
    wr(16'h400C, 32'd0);
    wr(16'h4008, 32'd20);
    repeat (12) cyc();
    chk("mtime_at_20", mtime, 64'd20);
    chk("irq_before_cmp", 64'(timer_irq), 64'd0);
    cyc();
    chk("irq_after_cmp", 64'(timer_irq), 64'b10);

    // Write on a tick cycle wins.
    wr(A_MLO, 32'd100);
    chk("mtime_write_no_inc", mtime, 64'd100);

    // PRESC=3: one increment every 4 cycles.
    wr(A_CTRL, 32'h8000_0003);
    chk("presc_start", mtime, 64'd101);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("presc_cyc%0d", i), mtime, 64'(101 + i / 4));
    end
    rd(A_CTRL, 32'h8000_0003);

    // EN=0 freezes mtime.
    wr(A_CTRL, 32'h0000_0000);
    wr(A_MLO, 32'd500);
    cyc();
    chk("frozen_1", mtime, 64'd500);
    repeat (49) cyc();
    chk("frozen_50", mtime, 64'd500);

    // Carry from low into high half.
    wr(A_MLO, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h8000_0000);
    chk("carry_pre", mtime, 64'h0000_0000_FFFF_FFFF);
    cyc();
    chk("carry_post", mtime, 64'h0000_0001_0000_0000);
    rd(A_MHI, 32'd1);
    rd(A_MLO, 32'd1);

    // Full 64-bit wrap: irq[0] pulses at all-ones, irq[1] clears after wrap.
    wr(A_MHI, 32'hFFFF_FFFF);
    wr(A_MLO, 32'hFFFF_FFFF);
    chk("wrap_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_irq_a", 64'(timer_irq), 64'b10);
    cyc();
    chk("wrap_zero", mtime, 64'd0);
    chk("wrap_irq_b", 64'(timer_irq), 64'b11);
    cyc();
    chk("wrap_one", mtime, 64'd1);
    chk("wrap_irq_c", 64'(timer_irq), 64'b00);

    // MSIP and unmapped accesses.
    wr(16'h0004, 32'd1);
    chk("msip1_set", 64'(sw_irq), 64'b10);
    rd(16'h0004, 32'd1);
    wr(16'h0004, 32'd0);
    chk("msip1_clr", 64'(sw_irq), 64'b00);
    wr(16'h0000, 32'hFFFF_FFFF);
    chk("msip0_set", 64'(sw_irq), 64'b01);
    rd(16'h0000, 32'd1);
    rd(16'h0002, 32'd1);
    wr(16'h0008, 32'd1);
    chk("msip_unmapped_wr", 64'(sw_irq), 64'b01);
    rd(16'h0008, 32'd0);
    rd(16'h4010, 32'd0);
    rd(16'h5000, 32'd0);

    // Read/write collision returns the old value.
    rdwr(16'h4008, 32'd55, 32'd20);
    rd(16'h4008, 32'd55);
    wr(A_MHI, 32'd5);
    cyc();
    chk("irq_pre_reset", 64'(timer_irq), 64'b10);

    // Async reset with a read in flight.
    mmr_addr = 16'h4008; mmr_rd = 1'b1;
    #2 reset_in = 1'b1;
    #1;
    chk("async_mtime", mtime, 64'd0);
    chk("async_timer_irq", 64'(timer_irq), 64'd0);
    chk("async_sw_irq", 64'(sw_irq), 64'd0);
    chk("async_rd_data", 64'(mmr_rd_data), 64'd0);
    chk("async_rd_valid", 64'(mmr_rd_valid), 64'd0);
    mmr_rd = 1'b0;
    cyc();
    cyc();
    reset_in = 1'b0;
    cyc();
    chk("post_reset_rd_valid", 64'(mmr_rd_valid), 64'd0);
    rd(16'h4008, 32'hFFFF_FFFF);
    rd(A_CTRL, 32'h8000_0000);
    rd(16'h0000, 32'd0);
    cyc();
    cyc();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
